// File: rtl/matrixmult_mac_pkg.sv
// ---------------------------------------------------------------------------
// matrixmult_mac_pkg
//   Shared definitions for the matrix-multiplication MAC datapath:
//   derived-width helpers, saturation bound builders and the packed
//   {valid, product} element that travels down the multiplier pipeline.
//   Consumers: matrixmult_mul_pipe, matrixmult_mac_pipe.
// ---------------------------------------------------------------------------
package matrixmult_mac_pkg;

    // Widest full-precision product carried by a pipeline element.
    localparam int MAX_PROD_W = 64;
    // Width used to build saturation bounds before trimming to ACC_WIDTH.
    localparam int BOUND_W    = 128;

    // Pipeline element. Products narrower than MAX_PROD_W occupy the low
    // bits; the upper bits are held at zero and fall away in synthesis.
    typedef struct packed {
        logic                  valid;
        logic [MAX_PROD_W-1:0] prod;
    } mul_elem_t;

    function automatic int prod_width(input int din0_w, input int din1_w);
        return din0_w + din1_w;
    endfunction

    // Counter must be able to represent 0..dot_len-1 (sized for dot_len).
    function automatic int cnt_width(input int dot_len);
        return $clog2(dot_len + 1);
    endfunction

    // Largest positive value representable in a w-bit signed result.
    function automatic logic [BOUND_W-1:0] sat_hi_bound(input int w);
        return (BOUND_W'(1) << (w - 1)) - BOUND_W'(1);
    endfunction

    // Most negative value of a w-bit signed result, sign-extended.
    function automatic logic [BOUND_W-1:0] sat_lo_bound(input int w);
        return ~sat_hi_bound(w);
    endfunction

endpackage

// File: rtl/matrixmult_mac_pipe_mul.sv
// ---------------------------------------------------------------------------
// matrixmult_mul_pipe
//   Signed full-precision multiplier followed by NUM_STAGE clock-enabled
//   registers. A valid tag rides along with each product. No reduction.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous active-low reset
//     ce         in   clock enable for the pipeline registers
//     clear      in   synchronous flush of all valid tags (ignores ce)
//     in_valid   in   din0/din1 carry an element pair
//     din0       in   signed operand A, DIN0_WIDTH bits
//     din1       in   signed operand B, DIN1_WIDTH bits
//     out_valid  out  tag of the product leaving the last stage
//     prod       out  signed product, DIN0_WIDTH+DIN1_WIDTH bits
// ---------------------------------------------------------------------------
module matrixmult_mul_pipe
    import matrixmult_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int NUM_STAGE  = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     ce,
    input  logic                                     clear,
    input  logic                                     in_valid,
    input  logic signed [DIN0_WIDTH-1:0]             din0,
    input  logic signed [DIN1_WIDTH-1:0]             din1,
    output logic                                     out_valid,
    output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0]  prod
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    logic signed [PW-1:0] product;
    mul_elem_t            head;
    mul_elem_t            stage_q [NUM_STAGE];
    logic                 unused_hi;

    always_comb begin
        product            = PW'(din0) * PW'(din1);
        head               = '0;
        head.valid         = in_valid;
        head.prod[PW-1:0]  = product;
    end

    // clear only needs to kill the tags; stale product bits are harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                stage_q[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else if (ce) begin
            stage_q[0] <= head;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[NUM_STAGE-1].valid;
    assign prod      = stage_q[NUM_STAGE-1].prod[PW-1:0];
    assign unused_hi = |(stage_q[NUM_STAGE-1].prod >> PW);

endmodule

// File: rtl/matrixmult_mac_pipe.sv
// ---------------------------------------------------------------------------
// matrixmult_mac_pipe
//   Pipelined signed multiply-accumulate: sums DOT_LEN consecutive valid
//   products into one dot-product result and strobes it out.
//
//   Build option: define MATRIXMULT_MAC_SAT_EN to clamp results to the
//   DOUT_WIDTH signed range and report clamping on sat; otherwise results
//   are truncated to the low DOUT_WIDTH bits and sat is tied low.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous active-low reset
//     ce         in   clock enable; all state holds when low
//     clear      in   synchronous abort of the current dot product
//     in_valid   in   din0/din1 carry an element pair
//     din0       in   signed operand A, DIN0_WIDTH bits
//     din1       in   signed operand B, DIN1_WIDTH bits
//     out_valid  out  one-cycle (ce-enabled) strobe: dout holds a new result
//     dout       out  signed dot-product result, DOUT_WIDTH bits
//     sat        out  dout was clamped
// ---------------------------------------------------------------------------
module matrixmult_mac_pipe
    import matrixmult_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 32,
    parameter int NUM_STAGE  = 2,
    parameter int DOT_LEN    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic signed [DIN0_WIDTH-1:0]  din0,
    input  logic signed [DIN1_WIDTH-1:0]  din1,
    output logic                          out_valid,
    output logic signed [DOUT_WIDTH-1:0]  dout,
    output logic                          sat
);

    localparam int            PW       = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int            CW       = cnt_width(DOT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(DOT_LEN - 1);

    logic                         mul_valid;
    logic signed [PW-1:0]         mul_prod;

    logic [CW-1:0]                cnt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DOUT_WIDTH-1:0] fit_val;

    matrixmult_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .clear     (clear),
        .in_valid  (in_valid),
        .din0      (din0),
        .din1      (din1),
        .out_valid (mul_valid),
        .prod      (mul_prod)
    );

    // The first product of a group replaces acc, so acc never needs an
    // explicit reload between back-to-back groups.
    always_comb begin
        prod_ext = ACC_WIDTH'(mul_prod);
        sum      = (cnt == '0) ? prod_ext : acc + prod_ext;
    end

`ifdef MATRIXMULT_MAC_SAT_EN
    localparam logic [BOUND_W-1:0]         SAT_HI_W = sat_hi_bound(DOUT_WIDTH);
    localparam logic [BOUND_W-1:0]         SAT_LO_W = sat_lo_bound(DOUT_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI  = SAT_HI_W[ACC_WIDTH-1:0];
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO  = SAT_LO_W[ACC_WIDTH-1:0];

    logic fit_sat;
    logic sat_q;

    always_comb begin
        fit_val = sum[DOUT_WIDTH-1:0];
        fit_sat = 1'b0;
        if (sum > SAT_HI) begin
            fit_val = SAT_HI[DOUT_WIDTH-1:0];
            fit_sat = 1'b1;
        end else if (sum < SAT_LO) begin
            fit_val = SAT_LO[DOUT_WIDTH-1:0];
            fit_sat = 1'b1;
        end
    end

    // sat tracks dout: it only changes when a result is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (clear) begin
            sat_q <= 1'b0;
        end else if (ce && mul_valid && (cnt == CNT_LAST)) begin
            sat_q <= fit_sat;
        end
    end

    assign sat = sat_q;
`else
    assign fit_val = sum[DOUT_WIDTH-1:0];
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (clear) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (mul_valid) begin
                if (cnt == CNT_LAST) begin
                    dout      <= fit_val;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc       <= sum;
                    cnt       <= cnt + CW'(1);
                    out_valid <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrixmult_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_matrixmult_mac_pipe
//   Scoreboard bench for matrixmult_mac_pipe with DOT_LEN = 4, NUM_STAGE = 2,
//   DOUT_WIDTH = 16. Expected results (value, sat flag, due ce-edge) are
//   queued as each group's last element is accepted and popped on strobes.
// ---------------------------------------------------------------------------
module tb_matrixmult_mac_pipe;

    localparam int DIN0_WIDTH = 16;
    localparam int DIN1_WIDTH = 16;
    localparam int ACC_WIDTH  = 40;
    localparam int DOUT_WIDTH = 16;
    localparam int NUM_STAGE  = 2;
    localparam int DOT_LEN    = 4;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          ce;
    logic                          clear;
    logic                          in_valid;
    logic signed [DIN0_WIDTH-1:0]  din0;
    logic signed [DIN1_WIDTH-1:0]  din1;
    logic                          out_valid;
    logic signed [DOUT_WIDTH-1:0]  dout;
    logic                          sat;

    always #5 clk = ~clk;

    matrixmult_mac_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .DOT_LEN    (DOT_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .clear     (clear),
        .in_valid  (in_valid),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .dout      (dout),
        .sat       (sat)
    );

    typedef struct {
        longint dout;
        logic   sat;
        longint due;
    } exp_t;

    exp_t   sb [$];
    exp_t   e;
    int     checks = 0;
    int     errors = 0;
    longint ce_edges = 0;
    logic   edge_ce = 1'b0;
    longint last_dout = 0;
    longint m_acc = 0;
    int     m_cnt = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void fit(input longint s, output longint v, output logic f);
        logic signed [15:0] t;
        t = s[15:0];
        v = t;
        f = 1'b0;
`ifdef MATRIXMULT_MAC_SAT_EN
        if (s > 32767) begin
            v = 32767;
            f = 1'b1;
        end else if (s < -32768) begin
            v = -32768;
            f = 1'b1;
        end else begin
            v = s;
        end
`endif
    endfunction

    // Count ce-enabled pipeline-advancing edges; note whether this edge advanced.
    always @(posedge clk) begin
        edge_ce = reset && ce && !clear;
        if (reset && ce && !clear) ce_edges++;
    end

    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (edge_ce) begin
                if (sb.size() == 0) begin
                    check("spurious_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("dout", dout, e.dout);
                    check("sat", sat, e.sat);
                    check("latency", ce_edges, e.due);
                    last_dout = e.dout;
                end
            end else begin
                check("hold_dout", dout, last_dout);
            end
        end
    end

    function automatic void model_accept(input longint p);
        exp_t   x;
        longint v;
        logic   f;
        m_acc = (m_cnt == 0) ? p : m_acc + p;
        if (m_cnt == DOT_LEN - 1) begin
            fit(m_acc, v, f);
            x.dout = v;
            x.sat  = f;
            x.due  = ce_edges + NUM_STAGE;
            sb.push_back(x);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic send(input longint a, input longint b);
        ce       = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b1;
        din0     = 16'(a);
        din1     = 16'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(a * b);
    endtask

    task automatic idle(input int n);
        ce       = 1'b1;
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ce low with junk presented as valid: nothing may be accepted.
    task automatic stall(input int n);
        ce       = 1'b0;
        in_valid = 1'b1;
        din0     = 16'sd100;
        din1     = 16'sd100;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ce       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        ce       = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_sat", sat, 0);
        reset = 1'b1;
        idle(2);

        // Basic group: -72
        send(1, 2); send(3, 4); send(-5, 6); send(7, -8);
        idle(4);

        // Bubbles, mid-group stall, and a stall landing on the strobe
        send(1, 2); idle(1); send(3, 4); stall(3);
        send(-5, 6); idle(2); send(7, -8);
        idle(2);
        stall(3);
        idle(4);

        // Back-to-back groups: 4 then -4
        for (int i = 0; i < 4; i++) send(1, 1);
        for (int i = 0; i < 4; i++) send(-1, 1);
        idle(4);

        // Overflow of the 16-bit result
        for (int i = 0; i < 4; i++) send(32767, 32767);
        idle(4);

        // Asynchronous reset mid-group
        send(5, 5); send(5, 5);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_dout", dout, 0);
        check("async_rst_sat", sat, 0);
        reset = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) send(2, 2);
        idle(4);

        // clear with ce low aborts the partial group and drops its input
        send(4, 4); send(4, 4); send(4, 4);
        ce       = 1'b0;
        clear    = 1'b1;
        in_valid = 1'b1;
        din0     = 16'sd9;
        din1     = 16'sd9;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        ce       = 1'b1;
        check("clear_out_valid", out_valid, 0);
        m_acc = 0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) send(1, 3);
        idle(6);

        check("results_pending", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
